// File: rtl/rom_arbiter.sv
// rom_arbiter: two-master (fetch/data) arbiter in front of rom_controller.
// Macro ROM_ARB_RR_EN selects round-robin; default is fixed m1 priority.
`ifndef ROM_VA_WIDTH
`define ROM_VA_WIDTH 16
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

module rom_arbiter (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [`ROM_VA_WIDTH-1:0]  m0_addr,
  input  logic                      m0_w_rb,
  input  logic [`BUS_ACC_WIDTH-1:0] m0_acc,
  input  logic [`BUS_WIDTH-1:0]     m0_wdata,
  input  logic                      m0_req,
  output logic [`BUS_WIDTH-1:0]     m0_rdata,
  output logic                      m0_resp,
  output logic                      m0_fault,
  input  logic [`ROM_VA_WIDTH-1:0]  m1_addr,
  input  logic                      m1_w_rb,
  input  logic [`BUS_ACC_WIDTH-1:0] m1_acc,
  input  logic [`BUS_WIDTH-1:0]     m1_wdata,
  input  logic                      m1_req,
  output logic [`BUS_WIDTH-1:0]     m1_rdata,
  output logic                      m1_resp,
  output logic                      m1_fault,
  output logic [`ROM_VA_WIDTH-1:0]  s_addr,
  output logic                      s_w_rb,
  output logic [`BUS_ACC_WIDTH-1:0] s_acc,
  output logic [`BUS_WIDTH-1:0]     s_wdata,
  output logic                      s_req,
  input  logic [`BUS_WIDTH-1:0]     s_rdata,
  input  logic                      s_resp,
  input  logic                      s_fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT0 = 2'd1,
    WAIT1 = 2'd2
  } state_t;

  state_t state;
  logic   issue;
  logic   g;

`ifdef ROM_ARB_RR_EN
  logic last_g;
`endif

  // Grant choice and issue-cycle detection; reset blanks all activity.
  always_comb begin
    issue = !rst && (state == IDLE) && (m0_req || m1_req);
`ifdef ROM_ARB_RR_EN
    g = (m0_req && m1_req) ? ~last_g : m1_req;
`else
    g = m1_req;
`endif
  end

  // Request mux toward the controller, open only in the issue cycle.
  always_comb begin
    s_req   = 1'b0;
    s_addr  = '0;
    s_w_rb  = 1'b0;
    s_acc   = '0;
    s_wdata = '0;
    if (issue) begin
      s_req = 1'b1;
      if (g) begin
        s_addr  = m1_addr;
        s_w_rb  = m1_w_rb;
        s_acc   = m1_acc;
        s_wdata = m1_wdata;
      end else begin
        s_addr  = m0_addr;
        s_w_rb  = m0_w_rb;
        s_acc   = m0_acc;
        s_wdata = m0_wdata;
      end
    end
  end

  // Route fault/response back to the owning master only.
  always_comb begin
    m0_resp  = 1'b0;
    m1_resp  = 1'b0;
    m0_fault = 1'b0;
    m1_fault = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    if (issue) begin
      m0_fault = !g && s_fault;
      m1_fault = g && s_fault;
    end
    if (!rst && state == WAIT0 && s_resp) begin
      m0_resp  = 1'b1;
      m0_rdata = s_rdata;
    end
    if (!rst && state == WAIT1 && s_resp) begin
      m1_resp  = 1'b1;
      m1_rdata = s_rdata;
    end
  end

  // Transaction FSM: a faulted issue never leaves IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (issue && !s_fault)
            state <= g ? WAIT1 : WAIT0;
        end
        WAIT0, WAIT1: begin
          if (s_resp)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROM_ARB_RR_EN
  // Remember the last granted master, faulted issues included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_g <= 1'b0;
    else if (issue)
      last_g <= g;
  end
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed tests for rom_arbiter against a small ROM model.
// Works in both the fixed-priority and ROM_ARB_RR_EN builds.
`ifndef ROM_VA_WIDTH
`define ROM_VA_WIDTH 16
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

module tb_rom_arbiter;

  localparam int VA = `ROM_VA_WIDTH;
  localparam int AW = `BUS_ACC_WIDTH;
  localparam int BW = `BUS_WIDTH;

`ifdef ROM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [VA-1:0] m0_addr = '0;
  logic          m0_w_rb = 1'b0;
  logic [AW-1:0] m0_acc = '0;
  logic [BW-1:0] m0_wdata = '0;
  logic          m0_req = 1'b0;
  logic [BW-1:0] m0_rdata;
  logic          m0_resp;
  logic          m0_fault;
  logic [VA-1:0] m1_addr = '0;
  logic          m1_w_rb = 1'b0;
  logic [AW-1:0] m1_acc = '0;
  logic [BW-1:0] m1_wdata = '0;
  logic          m1_req = 1'b0;
  logic [BW-1:0] m1_rdata;
  logic          m1_resp;
  logic          m1_fault;
  logic [VA-1:0] s_addr;
  logic          s_w_rb;
  logic [AW-1:0] s_acc;
  logic [BW-1:0] s_wdata;
  logic          s_req;
  logic [BW-1:0] s_rdata;
  logic          s_resp;
  logic          s_fault;

  int n_checks = 0;
  int n_fail = 0;

  rom_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_w_rb(m0_w_rb), .m0_acc(m0_acc),
    .m0_wdata(m0_wdata), .m0_req(m0_req), .m0_rdata(m0_rdata),
    .m0_resp(m0_resp), .m0_fault(m0_fault),
    .m1_addr(m1_addr), .m1_w_rb(m1_w_rb), .m1_acc(m1_acc),
    .m1_wdata(m1_wdata), .m1_req(m1_req), .m1_rdata(m1_rdata),
    .m1_resp(m1_resp), .m1_fault(m1_fault),
    .s_addr(s_addr), .s_w_rb(s_w_rb), .s_acc(s_acc),
    .s_wdata(s_wdata), .s_req(s_req), .s_rdata(s_rdata),
    .s_resp(s_resp), .s_fault(s_fault)
  );

  always #5 clk = ~clk;

  // ROM model: acc 0=1B 1=2B 2=4B; writes and misaligned faults.
  function automatic logic [BW-1:0] word(input logic [VA-1:0] a);
    return BW'(32'hA500_0000 | 32'(a));
  endfunction

  int          lat = 1;
  int          cnt = 0;
  logic [VA-1:0] raddr = '0;
  logic        misal;

  assign misal = (s_acc == 2'd1 && s_addr[0]) ||
                 (s_acc == 2'd2 && s_addr[1:0] != 2'b00);
  assign s_fault = s_req && (s_w_rb || misal);
  assign s_resp = (cnt == 1);
  assign s_rdata = s_resp ? word(raddr) : '0;

  always @(posedge clk) begin
    if (s_req && !s_fault) begin
      cnt <= lat;
      raddr <= s_addr;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_req = 1'b1;
    m0_addr = 16'h0010;
    m0_acc = 2'd2;
    nxt();
    mid();
    n_checks++;
    if (s_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_s_req got %b exp 0", s_req);
    end
    n_checks++;
    if (s_addr !== '0 || s_acc !== '0 || s_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_s_bus got %h/%h/%h exp 0",
               s_addr, s_acc, s_wdata);
    end
    n_checks++;
    if ({m0_resp, m0_fault, m1_resp, m1_fault} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 0000",
               {m0_resp, m0_fault, m1_resp, m1_fault});
    end
    n_checks++;
    if (m0_rdata !== '0 || m1_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_rdata got %h/%h exp 0", m0_rdata, m1_rdata);
    end
    m0_req = 1'b0;
    nxt();
    rst = 1'b0;
    nxt();
  endtask

  task automatic test_single_read();
    m0_req = 1'b1;
    m0_addr = 16'h0010;
    m0_acc = 2'd2;
    m0_w_rb = 1'b0;
    mid();
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 16'h0010 || s_acc !== 2'd2) begin
      n_fail++;
      $display("FAIL single_issue got req=%b addr=%h acc=%h exp 1/0010/2",
               s_req, s_addr, s_acc);
    end
    nxt();
    mid();
    n_checks++;
    if (m0_resp !== 1'b1 || m0_rdata !== word(16'h0010)) begin
      n_fail++;
      $display("FAIL single_resp got %b/%h exp 1/%h",
               m0_resp, m0_rdata, word(16'h0010));
    end
    n_checks++;
    if (s_req !== 1'b0 || s_addr !== '0) begin
      n_fail++;
      $display("FAIL single_wait_bus got %b/%h exp 0/0", s_req, s_addr);
    end
    nxt();
    m0_req = 1'b0;
    m1_req = 1'b1;
    m1_addr = 16'h0020;
    m1_acc = 2'd2;
    mid();
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 16'h0020) begin
      n_fail++;
      $display("FAIL single_idle_again got %b/%h exp 1/0020",
               s_req, s_addr);
    end
    n_checks++;
    if (m0_resp !== 1'b0 || m0_rdata !== '0) begin
      n_fail++;
      $display("FAIL single_no_resp got %b/%h exp 0/0", m0_resp, m0_rdata);
    end
    nxt();
    mid();
    n_checks++;
    if (m1_resp !== 1'b1 || m1_rdata !== word(16'h0020)) begin
      n_fail++;
      $display("FAIL single_m1_resp got %b/%h exp 1/%h",
               m1_resp, m1_rdata, word(16'h0020));
    end
    nxt();
    m1_req = 1'b0;
    mid();
    n_checks++;
    if (s_req !== 1'b0) begin
      n_fail++;
      $display("FAIL single_quiet got %b exp 0", s_req);
    end
    nxt();
  endtask

  task automatic test_contention();
    logic          first;
    logic [VA-1:0] a_first;
    logic [VA-1:0] a_second;
    first = RR ? 1'b0 : 1'b1;
    a_first = first ? 16'h0080 : 16'h0040;
    a_second = first ? 16'h0040 : 16'h0080;
    m0_req = 1'b1;
    m0_addr = 16'h0040;
    m0_acc = 2'd2;
    m1_req = 1'b1;
    m1_addr = 16'h0080;
    m1_acc = 2'd2;
    mid();
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== a_first) begin
      n_fail++;
      $display("FAIL cont_first got %b/%h exp 1/%h",
               s_req, s_addr, a_first);
    end
    nxt();
    mid();
    n_checks++;
    if ({m1_resp, m0_resp} !== (first ? 2'b10 : 2'b01)) begin
      n_fail++;
      $display("FAIL cont_resp1 got %b exp %b",
               {m1_resp, m0_resp}, (first ? 2'b10 : 2'b01));
    end
    n_checks++;
    if ((first ? m0_rdata : m1_rdata) !== '0) begin
      n_fail++;
      $display("FAIL cont_loser_rdata got %h exp 0",
               first ? m0_rdata : m1_rdata);
    end
    nxt();
    if (first) m1_req = 1'b0;
    else m0_req = 1'b0;
    mid();
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== a_second) begin
      n_fail++;
      $display("FAIL cont_second got %b/%h exp 1/%h",
               s_req, s_addr, a_second);
    end
    nxt();
    mid();
    n_checks++;
    if ((first ? m0_resp : m1_resp) !== 1'b1 ||
        (first ? m0_rdata : m1_rdata) !== word(a_second)) begin
      n_fail++;
      $display("FAIL cont_resp2 got %b/%h exp 1/%h",
               first ? m0_resp : m1_resp,
               first ? m0_rdata : m1_rdata, word(a_second));
    end
    nxt();
    m0_req = 1'b0;
    m1_req = 1'b0;
    nxt();
  endtask

  task automatic test_fault_misaligned();
    m1_req = 1'b1;
    m1_addr = 16'h0003;
    m1_acc = 2'd1;
    mid();
    n_checks++;
    if (m1_fault !== 1'b1 || s_req !== 1'b1 || m0_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL misal_fault got m1f=%b sreq=%b m0f=%b exp 1/1/0",
               m1_fault, s_req, m0_fault);
    end
    nxt();
    m1_req = 1'b0;
    m0_req = 1'b1;
    m0_addr = 16'h000C;
    m0_acc = 2'd2;
    mid();
    n_checks++;
    if (m1_resp !== 1'b0 || m1_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL misal_no_resp got %b/%b exp 0/0", m1_resp, m1_fault);
    end
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 16'h000C) begin
      n_fail++;
      $display("FAIL misal_next_issue got %b/%h exp 1/000c", s_req, s_addr);
    end
    nxt();
    mid();
    n_checks++;
    if (m0_resp !== 1'b1 || m0_rdata !== word(16'h000C)) begin
      n_fail++;
      $display("FAIL misal_m0_resp got %b/%h exp 1/%h",
               m0_resp, m0_rdata, word(16'h000C));
    end
    nxt();
    m0_req = 1'b0;
    nxt();
  endtask

  task automatic test_fault_write();
    m0_req = 1'b1;
    m0_addr = 16'h0050;
    m0_acc = 2'd2;
    m1_req = 1'b1;
    m1_addr = 16'h0060;
    m1_acc = 2'd2;
    m1_w_rb = 1'b1;
    m1_wdata = 32'hDEAD_BEEF;
    mid();
    n_checks++;
    if (m1_fault !== 1'b1 || m0_fault !== 1'b0 || m0_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_fault got m1f=%b m0f=%b m0r=%b exp 1/0/0",
               m1_fault, m0_fault, m0_resp);
    end
    n_checks++;
    if (s_w_rb !== 1'b1 || s_wdata !== 32'hDEAD_BEEF ||
        s_addr !== 16'h0060) begin
      n_fail++;
      $display("FAIL wr_fwd got %b/%h/%h exp 1/deadbeef/0060",
               s_w_rb, s_wdata, s_addr);
    end
    nxt();
    m1_req = 1'b0;
    m1_w_rb = 1'b0;
    m1_wdata = '0;
    mid();
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 16'h0050 || s_w_rb !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_m0_pending got %b/%h/%b exp 1/0050/0",
               s_req, s_addr, s_w_rb);
    end
    nxt();
    mid();
    n_checks++;
    if (m0_resp !== 1'b1 || m0_rdata !== word(16'h0050)) begin
      n_fail++;
      $display("FAIL wr_m0_resp got %b/%h exp 1/%h",
               m0_resp, m0_rdata, word(16'h0050));
    end
    nxt();
    m0_req = 1'b0;
    nxt();
  endtask

  task automatic test_reset_abort();
    lat = 2;
    m0_req = 1'b1;
    m0_addr = 16'h0010;
    m0_acc = 2'd2;
    mid();
    n_checks++;
    if (s_req !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_issue got %b exp 1", s_req);
    end
    nxt();
    mid();
    n_checks++;
    if (m0_resp !== 1'b0 || s_req !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_wait got %b/%b exp 0/0", m0_resp, s_req);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (s_req !== 1'b0 || s_addr !== '0 ||
        {m0_resp, m0_fault, m1_resp, m1_fault} !== 4'b0 ||
        m0_rdata !== '0 || m1_rdata !== '0) begin
      n_fail++;
      $display("FAIL abort_outs_zero got req=%b addr=%h flags=%b",
               s_req, s_addr, {m0_resp, m0_fault, m1_resp, m1_fault});
    end
    m0_req = 1'b0;
    #1;
    rst = 1'b0;
    nxt();
    mid();
    n_checks++;
    if (s_resp !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_stale_setup got %b exp 1", s_resp);
    end
    n_checks++;
    if (m0_resp !== 1'b0 || m0_rdata !== '0 || m1_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_stale_ignored got %b/%h/%b exp 0/0/0",
               m0_resp, m0_rdata, m1_resp);
    end
    nxt();
    lat = 1;
    m0_req = 1'b1;
    mid();
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 16'h0010) begin
      n_fail++;
      $display("FAIL abort_rereq got %b/%h exp 1/0010", s_req, s_addr);
    end
    nxt();
    mid();
    n_checks++;
    if (m0_resp !== 1'b1 || m0_rdata !== word(16'h0010)) begin
      n_fail++;
      $display("FAIL abort_rereq_resp got %b/%h exp 1/%h",
               m0_resp, m0_rdata, word(16'h0010));
    end
    nxt();
    m0_req = 1'b0;
    nxt();
  endtask

  task automatic test_back_to_back();
    int            n0;
    int            n1;
    logic          eg;
    logic [VA-1:0] ea;
    n0 = 0;
    n1 = 0;
    m0_req = 1'b1;
    m0_addr = 16'h0100;
    m0_acc = 2'd2;
    m1_req = 1'b1;
    m1_addr = 16'h0200;
    m1_acc = 2'd2;
    for (int k = 0; k < 8; k++) begin
      eg = RR ? ((k % 2) == 0) : 1'b1;
      ea = eg ? 16'h0200 : 16'h0100;
      mid();
      if (s_req && s_addr == 16'h0100) n0++;
      if (s_req && s_addr == 16'h0200) n1++;
      n_checks++;
      if (s_req !== 1'b1 || s_addr !== ea) begin
        n_fail++;
        $display("FAIL b2b_issue%0d got %b/%h exp 1/%h",
                 k, s_req, s_addr, ea);
      end
      nxt();
      mid();
      n_checks++;
      if ({m1_resp, m0_resp} !== (eg ? 2'b10 : 2'b01) ||
          (eg ? m1_rdata : m0_rdata) !== word(ea)) begin
        n_fail++;
        $display("FAIL b2b_resp%0d got %b exp %b",
                 k, {m1_resp, m0_resp}, (eg ? 2'b10 : 2'b01));
      end
      nxt();
    end
    n_checks++;
    if (n0 !== (RR ? 4 : 0) || n1 !== (RR ? 4 : 8)) begin
      n_fail++;
      $display("FAIL b2b_counts got %0d/%0d exp %0d/%0d",
               n0, n1, RR ? 4 : 0, RR ? 4 : 8);
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    nxt();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_fault_misaligned();
    test_fault_write();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
